// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_t    : FSM state encoding
//   PC_INC           : byte increment between consecutive 16-bit instruction words
//   DEFAULT_RESET_PC : default fetch address after reset (even)
package instruction_fetch_pkg;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_ISSUE = 2'd2,
      S_FAULT = 2'd3
   } fetch_state_t;

   localparam logic [15:0] PC_INC           = 16'd2;
   localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter register for the instruction fetch unit.
//   i_clk      : clock, rising edge
//   i_rst_n    : asynchronous active-low reset, loads RESET_PC
//   i_load     : load i_load_val (branch redirect), has priority over i_inc
//   i_load_val : redirect byte address
//   i_inc      : advance by PC_INC (memory acknowledge), 16-bit modulo
//   o_pc       : current program counter
module pc_reg
   import instruction_fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_load,
   input  logic [15:0] i_load_val,
   input  logic        i_inc,
   output logic [15:0] o_pc
);

   logic [15:0] r_pc;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pc <= RESET_PC;
      end else if (i_load) begin
         r_pc <= i_load_val;
      end else if (i_inc) begin
         r_pc <= r_pc + PC_INC;
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: requests 16-bit words from memory, holds the
// fetched word in the instruction register and hands it to the decoder
// with a one-cycle enable pulse.
//   Clock    : clock, rising edge
//   nReset   : asynchronous active-low reset
//   MAR      : fetch byte address (always the PC)
//   MemRd    : memory read strobe
//   MemAck   : memory data valid this cycle
//   MemData  : fetched instruction word
//   Stall    : decoder cannot accept an instruction this cycle
//   BrTaken  : one-cycle branch redirect request
//   BrTarget : redirect byte address
//   Instr    : instruction register to the decoder
//   E        : decoder enable, one cycle per issued instruction
//   PC       : address of the next fetch
//   FLTo     : sticky misaligned-fetch fault
//
// state   | meaning
// S_REQ   | present a read request at PC
// S_WAIT  | hold the request until MemAck, then latch word and advance PC
// S_ISSUE | word in Instr, pulse E unless the decoder stalls
// S_FAULT | misaligned branch seen, dead until reset
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        Clock,
   input  logic        nReset,
   output logic [15:0] MAR,
   output logic        MemRd,
   input  logic        MemAck,
   input  logic [15:0] MemData,
   input  logic        Stall,
   input  logic        BrTaken,
   input  logic [15:0] BrTarget,
   output logic [15:0] Instr,
   output logic        E,
   output logic [15:0] PC,
   output logic        FLTo
);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;
   logic [15:0]  r_instr;
   logic         r_flt;
   logic         r_started;
   logic [15:0]  w_pc;
   logic         w_br_even;
   logic         w_br_odd;
   logic         w_pc_load;
   logic         w_pc_inc;
   logic         w_instr_load;
   logic         w_issue;
   logic         w_flt_set;

   assign w_br_even = BrTaken & ~BrTarget[0];
   assign w_br_odd  = BrTaken &  BrTarget[0];

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .i_clk      (Clock),
      .i_rst_n    (nReset),
      .i_load     (w_pc_load),
      .i_load_val (BrTarget),
      .i_inc      (w_pc_inc),
      .o_pc       (w_pc)
   );

   // The first edge out of reset only arms the fetcher, so MemRd stays low
   // through the reset-release cycle and rises in the cycle that follows.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_started <= 1'b0;
      end else begin
         r_started <= 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_state <= S_REQ;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_instr <= 16'h0000;
      end else if (w_instr_load) begin
         r_instr <= MemData;
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_flt <= 1'b0;
      end else if (w_flt_set) begin
         r_flt <= 1'b1;
      end
   end

   // Redirects outrank everything else, including an ack arriving in the
   // same cycle and an issue pending in S_ISSUE.
   always_comb begin
      w_state_nxt  = r_state;
      w_pc_load    = 1'b0;
      w_pc_inc     = 1'b0;
      w_instr_load = 1'b0;
      w_issue      = 1'b0;
      w_flt_set    = 1'b0;
      if (r_started && (r_state != S_FAULT)) begin
         if (w_br_odd) begin
            w_state_nxt = S_FAULT;
            w_flt_set   = 1'b1;
         end else if (w_br_even) begin
            w_state_nxt = S_REQ;
            w_pc_load   = 1'b1;
         end else begin
            case (r_state)
               S_REQ: begin
                  w_state_nxt = S_WAIT;
               end
               S_WAIT: begin
                  if (MemAck) begin
                     w_instr_load = 1'b1;
                     w_pc_inc     = 1'b1;
                     w_state_nxt  = S_ISSUE;
                  end
               end
               S_ISSUE: begin
                  if (!Stall) begin
                     w_issue     = 1'b1;
                     w_state_nxt = S_REQ;
                  end
               end
               default: begin
                  w_state_nxt = r_state;
               end
            endcase
         end
      end
   end

   // A misaligned redirect drops the strobe in the same cycle it is seen.
   assign MemRd = r_started && ((r_state == S_REQ) || (r_state == S_WAIT)) && !w_br_odd;
   assign MAR   = w_pc;
   assign PC    = w_pc;
   assign E     = w_issue;
   assign Instr = r_instr;
   assign FLTo  = r_flt;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

   logic        Clock;
   logic        nReset;
   logic [15:0] MAR;
   logic        MemRd;
   logic        MemAck;
   logic [15:0] MemData;
   logic        Stall;
   logic        BrTaken;
   logic [15:0] BrTarget;
   logic [15:0] Instr;
   logic        E;
   logic [15:0] PC;
   logic        FLTo;

   int n_checks = 0;
   int n_fail   = 0;

   instruction_fetch dut (
      .Clock    (Clock),
      .nReset   (nReset),
      .MAR      (MAR),
      .MemRd    (MemRd),
      .MemAck   (MemAck),
      .MemData  (MemData),
      .Stall    (Stall),
      .BrTaken  (BrTaken),
      .BrTarget (BrTarget),
      .Instr    (Instr),
      .E        (E),
      .PC       (PC),
      .FLTo     (FLTo)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Memory contents as a function of address.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   // Drive one cycle's inputs away from the rising edge, then let them settle.
   task automatic set_in(input logic st, input logic br, input logic [15:0] tgt,
                         input logic ack, input logic [15:0] dat);
      @(negedge Clock);
      Stall = st; BrTaken = br; BrTarget = tgt; MemAck = ack; MemData = dat;
      #2;
   endtask

   // Leaves the bench such that the next set_in lands in the first S_REQ cycle.
   task automatic do_reset();
      @(negedge Clock);
      nReset = 1'b0;
      Stall = 0; BrTaken = 0; BrTarget = 0; MemAck = 0; MemData = 0;
      @(negedge Clock);
      nReset = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge Clock);
      nReset = 1'b0;
      Stall = 0; BrTaken = 0; BrTarget = 0; MemAck = 0; MemData = 0;
      #1;
      n_checks++; if (PC !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h want 0000", PC); end
      n_checks++; if (MAR !== 16'h0000) begin n_fail++; $display("FAIL reset_mar: got %h want 0000", MAR); end
      n_checks++; if (Instr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h want 0000", Instr); end
      n_checks++; if ({MemRd, E, FLTo} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got MemRd/E/FLTo=%b want 000", {MemRd, E, FLTo}); end
      @(negedge Clock);
      nReset = 1'b1;
      #1;
      n_checks++; if (MemRd !== 1'b0) begin n_fail++; $display("FAIL release_memrd: got %b want 0", MemRd); end
   endtask

   task automatic test_basic_fetch();
      do_reset();
      set_in(0, 0, 16'h0, 0, 16'h0);
      n_checks++; if ({MemRd, MAR} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL c1_req: got MemRd=%b MAR=%h want 1 0000", MemRd, MAR); end
      n_checks++; if (E !== 1'b0) begin n_fail++; $display("FAIL c1_e: got %b want 0", E); end
      set_in(0, 0, 16'h0, 1, 16'h4C81);
      n_checks++; if ({MemRd, MAR} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL c2_wait: got MemRd=%b MAR=%h want 1 0000", MemRd, MAR); end
      set_in(0, 0, 16'h0, 0, 16'h0);
      n_checks++; if (E !== 1'b1) begin n_fail++; $display("FAIL c3_e: got %b want 1", E); end
      n_checks++; if (Instr !== 16'h4C81) begin n_fail++; $display("FAIL c3_instr: got %h want 4C81", Instr); end
      n_checks++; if (PC !== 16'h0002) begin n_fail++; $display("FAIL c3_pc: got %h want 0002", PC); end
      set_in(0, 0, 16'h0, 0, 16'h0);
      n_checks++; if ({E, MemRd, MAR} !== {1'b0, 1'b1, 16'h0002}) begin n_fail++; $display("FAIL c4_req: got E=%b MemRd=%b MAR=%h want 0 1 0002", E, MemRd, MAR); end
   endtask

   task automatic test_stall();
      int pulses = 0;
      do_reset();
      set_in(0, 0, 16'h0, 0, 16'h0);
      set_in(0, 0, 16'h0, 1, 16'hBEEF);
      for (int i = 0; i < 4; i++) begin
         set_in(1, 0, 16'h0, 0, 16'h0);
         if (E === 1'b1) pulses++;
         n_checks++; if ({E, Instr} !== {1'b0, 16'hBEEF}) begin n_fail++; $display("FAIL stall_hold%0d: got E=%b Instr=%h want 0 BEEF", i, E, Instr); end
      end
      set_in(0, 0, 16'h0, 0, 16'h0);
      if (E === 1'b1) pulses++;
      n_checks++; if (E !== 1'b1) begin n_fail++; $display("FAIL stall_release: got E=%b want 1", E); end
      for (int i = 0; i < 3; i++) begin
         set_in(0, 0, 16'h0, 0, 16'h0);
         if (E === 1'b1) pulses++;
      end
      n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL stall_pulses: got %0d want 1", pulses); end
   endtask

   task automatic test_branch_with_ack();
      do_reset();
      set_in(0, 0, 16'h0, 0, 16'h0);
      set_in(0, 1, 16'h0100, 1, 16'h1234);
      n_checks++; if (E !== 1'b0) begin n_fail++; $display("FAIL brack_e: got %b want 0", E); end
      set_in(0, 0, 16'h0, 0, 16'h0);
      n_checks++; if ({E, Instr} !== {1'b0, 16'h0000}) begin n_fail++; $display("FAIL brack_discard: got E=%b Instr=%h want 0 0000", E, Instr); end
      n_checks++; if ({MemRd, MAR} !== {1'b1, 16'h0100}) begin n_fail++; $display("FAIL brack_mar: got MemRd=%b MAR=%h want 1 0100", MemRd, MAR); end
      set_in(0, 0, 16'h0, 1, 16'h5555);
      set_in(0, 0, 16'h0, 0, 16'h0);
      n_checks++; if ({E, Instr, PC} !== {1'b1, 16'h5555, 16'h0102}) begin n_fail++; $display("FAIL brack_resume: got E=%b Instr=%h PC=%h want 1 5555 0102", E, Instr, PC); end
   endtask

   task automatic test_branch_in_issue();
      do_reset();
      set_in(0, 0, 16'h0, 0, 16'h0);
      set_in(0, 0, 16'h0, 1, 16'h1111);
      set_in(0, 1, 16'h0200, 0, 16'h0);
      n_checks++; if (E !== 1'b0) begin n_fail++; $display("FAIL brissue_e: got %b want 0", E); end
      set_in(0, 0, 16'h0, 0, 16'h0);
      n_checks++; if ({E, MemRd, MAR, Instr} !== {1'b0, 1'b1, 16'h0200, 16'h1111}) begin n_fail++; $display("FAIL brissue_next: got E=%b MemRd=%b MAR=%h Instr=%h want 0 1 0200 1111", E, MemRd, MAR, Instr); end
   endtask

   task automatic test_wrap();
      do_reset();
      set_in(0, 1, 16'hFFFE, 0, 16'h0);
      set_in(0, 0, 16'h0, 0, 16'h0);
      n_checks++; if (MAR !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_mar0: got %h want FFFE", MAR); end
      set_in(0, 0, 16'h0, 1, 16'h7777);
      set_in(0, 0, 16'h0, 0, 16'h0);
      n_checks++; if ({E, PC} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL wrap_pc: got E=%b PC=%h want 1 0000", E, PC); end
      set_in(0, 0, 16'h0, 0, 16'h0);
      n_checks++; if ({MemRd, MAR} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL wrap_mar: got MemRd=%b MAR=%h want 1 0000", MemRd, MAR); end
   endtask

   task automatic test_fault();
      do_reset();
      set_in(0, 0, 16'h0, 0, 16'h0);
      set_in(0, 1, 16'h0101, 0, 16'h0);
      n_checks++; if (MemRd !== 1'b0) begin n_fail++; $display("FAIL fault_memrd_now: got %b want 0", MemRd); end
      set_in(0, 0, 16'h0, 0, 16'h0);
      n_checks++; if (FLTo !== 1'b1) begin n_fail++; $display("FAIL fault_flag: got %b want 1", FLTo); end
      for (int i = 0; i < 8; i++) begin
         set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                1'($urandom_range(0, 1)), 16'($urandom));
         n_checks++; if ({FLTo, MemRd, E} !== 3'b100) begin n_fail++; $display("FAIL fault_sticky%0d: got FLTo/MemRd/E=%b want 100", i, {FLTo, MemRd, E}); end
      end
      do_reset();
      n_checks++; if (FLTo !== 1'b0) begin n_fail++; $display("FAIL fault_clear: got %b want 0", FLTo); end
   endtask

   task automatic test_reset_mid_fetch();
      do_reset();
      set_in(0, 1, 16'h0040, 0, 16'h0);
      set_in(0, 0, 16'h0, 0, 16'h0);
      set_in(0, 0, 16'h0, 0, 16'h0);
      n_checks++; if ({MemRd, MAR} !== {1'b1, 16'h0040}) begin n_fail++; $display("FAIL mid_wait: got MemRd=%b MAR=%h want 1 0040", MemRd, MAR); end
      #1 nReset = 1'b0;
      #1;
      n_checks++; if ({MemRd, PC, MAR} !== {1'b0, 16'h0000, 16'h0000}) begin n_fail++; $display("FAIL mid_reset: got MemRd=%b PC=%h MAR=%h want 0 0000 0000", MemRd, PC, MAR); end
      @(negedge Clock);
      nReset = 1'b1; MemAck = 1'b1; MemData = 16'hDEAD;
      set_in(0, 0, 16'h0, 0, 16'h0);
      n_checks++; if ({MemRd, MAR, Instr} !== {1'b1, 16'h0000, 16'h0000}) begin n_fail++; $display("FAIL mid_resume: got MemRd=%b MAR=%h Instr=%h want 1 0000 0000", MemRd, MAR, Instr); end
      set_in(0, 0, 16'h0, 1, 16'h2468);
      set_in(0, 0, 16'h0, 0, 16'h0);
      n_checks++; if ({E, Instr} !== {1'b1, 16'h2468}) begin n_fail++; $display("FAIL mid_issue: got E=%b Instr=%h want 1 2468", E, Instr); end
   endtask

   // Reference: the decoder must see mem_word() of consecutive addresses in
   // program order, restarting at every branch target; a stall or branch
   // suppresses E, and any active read must point at the next program address.
   task automatic test_random();
      logic [15:0] next_addr;
      int          issued = 0;
      do_reset();
      next_addr = 16'h0000;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge Clock);
         Stall    = ($urandom_range(0, 2) == 0);
         BrTaken  = ($urandom_range(0, 15) == 0);
         BrTarget = 16'($urandom) & 16'hFFFE;
         #1;
         MemAck = 1'($urandom_range(0, 1));
         MemData = (MemAck && MemRd) ? mem_word(MAR) : 16'($urandom);
         #1;
         if (MemRd === 1'b1) begin
            n_checks++; if (MAR !== next_addr) begin n_fail++; $display("FAIL rnd_mar cyc%0d: got %h want %h", cyc, MAR, next_addr); end
         end
         if (Stall || BrTaken) begin
            n_checks++; if (E !== 1'b0) begin n_fail++; $display("FAIL rnd_e_blocked cyc%0d: got %b want 0", cyc, E); end
         end
         if (E === 1'b1) begin
            issued++;
            n_checks++; if (Instr !== mem_word(next_addr)) begin n_fail++; $display("FAIL rnd_instr cyc%0d: got %h want %h", cyc, Instr, mem_word(next_addr)); end
            next_addr = next_addr + 16'd2;
         end
         if (BrTaken) next_addr = BrTarget;
      end
      n_checks++; if (issued < 20) begin n_fail++; $display("FAIL rnd_progress: got %0d issues want at least 20", issued); end
   endtask

   initial begin
      nReset = 1'b0;
      Stall = 0; BrTaken = 0; BrTarget = 0; MemAck = 0; MemData = 0;
      test_reset();
      test_basic_fetch();
      test_stall();
      test_branch_with_ack();
      test_branch_in_issue();
      test_wrap();
      test_fault();
      test_reset_mid_fetch();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the PC value loaded on reset; it SHALL be even.
REQ-002 Clock  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 nReset  input  1  is the reset: asynchronous, active-low.
REQ-004 MAR  output  16  is the fetch byte address.
REQ-005 MemRd  output  1  is the memory read strobe.
REQ-006 MemAck  input  1  indicates MemData is valid this cycle.
REQ-007 MemData  input  16  is the fetched instruction word.
REQ-008 Stall  input  1  means the decoder cannot accept an instruction this cycle.
REQ-009 BrTaken  input  1  is a one-cycle branch redirect request.
REQ-010 BrTarget  input  16  is the redirect byte address.
REQ-011 Instr  output  16  is the instruction register, driving the decoder Instr input.
REQ-012 E  output  1  is the decoder enable; it SHALL be high for exactly one cycle per issued instruction.
REQ-013 PC  output  16  is the address of the next fetch.
REQ-014 FLTo  output  1  is the sticky misaligned-fetch fault flag.

Function
REQ-015 FSM states SHALL be S_REQ, S_WAIT, S_ISSUE and S_FAULT.
REQ-016 S_REQ: MemRd=1 and MAR=PC; next state S_WAIT.
REQ-017 S_WAIT: MemRd=1 and MAR=PC, held until MemAck=1.
- On MemAck, the block SHALL set Instr<=MemData and PC<=PC+2, and go to S_ISSUE.
REQ-018 S_ISSUE, Stall=0: E=1 for this cycle only; next state S_REQ.
REQ-019 S_ISSUE, Stall=1: E=0; remain in S_ISSUE with Instr held.
REQ-020 Minimum latency SHALL be one instruction per 3 cycles: REQ, WAIT with ack, ISSUE.
REQ-021 PC arithmetic SHALL be 16-bit modulo; 16'hFFFE+2 wraps to 16'h0000.
REQ-022 BrTaken=1 with BrTarget[0]=0, in any non-fault state:
- PC<=BrTarget.
- Any in-flight or just-acked word SHALL be discarded: Instr unchanged, E=0.
- Next state S_REQ.
REQ-023 BrTaken coinciding with MemAck in S_WAIT: the ack is consumed and the data discarded; the branch wins.
REQ-024 BrTaken in S_ISSUE: E SHALL be 0 that cycle; the redirect takes priority over issue.
REQ-025 BrTaken=1 with BrTarget[0]=1: FLTo<=1, MemRd=0, and the FSM goes to S_FAULT.
REQ-026 S_FAULT SHALL be terminal until reset: E=0, MemRd=0, all inputs ignored.
REQ-027 MemAck outside S_WAIT SHALL be ignored.

Reset
REQ-028 On nReset low, outputs SHALL immediately take these values:
- FSM=S_REQ, PC=RESET_PC, Instr=16'h0000.
- E=0, FLTo=0, MemRd=0.
REQ-029 While nReset is low, MAR SHALL equal RESET_PC.
REQ-030 On the first rising Clock edge after nReset deasserts, the block SHALL behave as in S_REQ, driving MemRd=1 in the following cycle.
REQ-031 Reset asserted mid-fetch SHALL abandon the fetch; a late MemAck after reset SHALL be ignored unless the block is in S_WAIT.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding, PC_INC=2 and the default RESET_PC.
REQ-033 One sub-module is natural: pc_reg, a 16-bit register with async reset, load (branch) and increment (ack).

Verification
REQ-034 Scenario: reset, then MemAck=1 in the first S_WAIT cycle with MemData=16'h4C81.
- Required: MAR=0000 with MemRd; Instr=4C81; E=1 on cycle 3; PC=0002.
REQ-035 Scenario: Stall=1 for 4 cycles during S_ISSUE.
- Required: E=0 and Instr stable throughout; E=1 on the first cycle after Stall drops; one E pulse total.
REQ-036 Scenario: BrTaken, BrTarget=16'h0100, coinciding with MemAck (MemData=16'h1234).
- Required: no E pulse; Instr unchanged; next MAR=0100.
REQ-037 Scenario: PC=16'hFFFE, then ack.
- Required: PC=0000; next MAR=0000.
REQ-038 Scenario: BrTaken with BrTarget=16'h0101.
- Required: FLTo=1 next cycle; MemRd=0 and E=0 thereafter, despite further MemAck or BrTaken, until nReset.
REQ-039 Scenario: nReset pulsed low while in S_WAIT.
- Required: immediate PC=RESET_PC and MemRd=0; normal fetch resumes after release.
